// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffers payload bytes from a valid/ready producer and
// frames them for uart_tx as SYNC_BYTE, payload..., optional checksum.
// A small byte engine issues one-cycle tx_dv requests and then follows
// the tx_busy handshake of uart_tx before the next byte may be issued.
module uart_tx_framer #(
   parameter int          DEPTH        = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter bit          ADD_CHECKSUM = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_byte,
   input  logic                     in_last,
   output logic                     tx_dv,
   output logic [7:0]               tx_byte,
   input  logic                     tx_busy,
   output logic                     frame_done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PTR_ONE    = 1;
   localparam logic [AW:0]   CNT_ONE    = 1;
   localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];

   // Frame-level states
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SYNC    = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CSUM    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // Byte engine states
   localparam logic [1:0] E_IDLE    = 2'd0;
   localparam logic [1:0] E_ISSUE   = 2'd1;
   localparam logic [1:0] E_WAIT_HI = 2'd2;
   localparam logic [1:0] E_WAIT_LO = 2'd3;

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [AW:0]   count_q;

   logic [2:0]    state_q, state_d;
   logic [1:0]    engState_q, engState_d;
   logic [7:0]    txByte_q, txByte_d;
   logic [7:0]    sum_q, sum_d;
   logic          frameDone_q, frameDone_d;

   logic          push;
   logic          pop;
   logic          issue;
   logic          empty;
   logic          engIdle;
   logic [7:0]    headByte;
   logic          headLast;

   assign in_ready   = (count_q != FULL_COUNT);
   assign push       = in_valid && in_ready;
   assign empty      = (count_q == '0);
   assign engIdle    = (engState_q == E_IDLE);
   assign headByte   = mem_q[rdPtr_q][7:0];
   assign headLast   = mem_q[rdPtr_q][8];

   assign tx_dv      = (engState_q == E_ISSUE);
   assign tx_byte    = txByte_q;
   assign frame_done = frameDone_q;
   assign fifo_count = count_q;

   // FIFO storage holds {last, byte}; contents need no reset because
   // occupancy is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {in_last, in_byte};
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_ONE;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Frame sequencer: decides which byte to send next and when the frame
   // is complete. It only hands a byte over while the engine is idle, so
   // DONE is reached only after the final byte has fully left uart_tx.
   always_comb begin
      state_d     = state_q;
      txByte_d    = txByte_q;
      sum_d       = sum_q;
      frameDone_d = 1'b0;
      pop         = 1'b0;
      issue       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (engIdle) begin
               issue    = 1'b1;
               txByte_d = SYNC_BYTE;
               sum_d    = '0;
               state_d  = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (engIdle && !empty) begin
               issue    = 1'b1;
               pop      = 1'b1;
               txByte_d = headByte;
               sum_d    = sum_q + headByte;
               if (headLast) begin
                  state_d = ADD_CHECKSUM ? S_CSUM : S_DONE;
               end
            end
         end
         S_CSUM: begin
            if (engIdle) begin
               issue    = 1'b1;
               txByte_d = ~sum_q + 8'd1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (engIdle) begin
               frameDone_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Byte engine: one ISSUE cycle drives tx_dv, then it tracks tx_busy
   // rising and falling so no request can overlap a byte in flight.
   always_comb begin
      engState_d = engState_q;
      case (engState_q)
         E_IDLE: begin
            if (issue) begin
               engState_d = E_ISSUE;
            end
         end
         E_ISSUE: begin
            engState_d = E_WAIT_HI;
         end
         E_WAIT_HI: begin
            if (tx_busy) begin
               engState_d = E_WAIT_LO;
            end
         end
         E_WAIT_LO: begin
            if (!tx_busy) begin
               engState_d = E_IDLE;
            end
         end
         default: begin
            engState_d = E_IDLE;
         end
      endcase
   end

   // State, output byte, checksum accumulator and done pulse registers;
   // reset abandons any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         engState_q  <= E_IDLE;
         txByte_q    <= '0;
         sum_q       <= '0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         engState_q  <= engState_d;
         txByte_q    <= txByte_d;
         sum_q       <= sum_d;
         frameDone_q <= frameDone_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed testbench for uart_tx_framer. Two instances are used: one with
// the checksum enabled and one without. Each is paired with a behavioural
// uart_tx stand-in that raises busy one clock after tx_dv, stays busy for
// ten bit times at four clocks per bit, and logs every byte it accepts.
module tb_uart_tx_framer;

   localparam int BUSY_CYCLES = 40;

   logic       clk;
   logic       reset;

   logic       inValidA, inReadyA, inLastA, txDvA, txBusyA, frameDoneA;
   logic [7:0] inByteA, txByteA;
   logic [4:0] fifoCountA;

   logic       inValidB, inReadyB, inLastB, txDvB, txBusyB, frameDoneB;
   logic [7:0] inByteB, txByteB;
   logic [4:0] fifoCountB;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         lastPushCyc = 0;

   logic [7:0] logA[$];
   logic [7:0] logB[$];
   int         dvCycA[$];
   int         doneCycA[$];
   int         busyCntA = 0, busyCntB = 0;
   logic [7:0] holdA = 8'h00, holdB = 8'h00;
   int         violA = 0, violB = 0;
   int         dvCntA = 0, dvCntB = 0;
   int         doneCntA = 0, doneCntB = 0;
   int         fallCycA = 0;
   int         readyViol = 0;
   int         maxCountA = 0;
   bit         sawFullA = 1'b0;

   uart_tx_framer #(.DEPTH(16), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1'b1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(inValidA), .in_ready(inReadyA), .in_byte(inByteA), .in_last(inLastA),
      .tx_dv(txDvA), .tx_byte(txByteA), .tx_busy(txBusyA),
      .frame_done(frameDoneA), .fifo_count(fifoCountA)
   );

   uart_tx_framer #(.DEPTH(16), .SYNC_BYTE(8'hA5), .ADD_CHECKSUM(1'b0)) dutNoCsum (
      .clk(clk), .reset(reset),
      .in_valid(inValidB), .in_ready(inReadyB), .in_byte(inByteB), .in_last(inLastB),
      .tx_dv(txDvB), .tx_byte(txByteB), .tx_busy(txBusyB),
      .frame_done(frameDoneB), .fifo_count(fifoCountB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in for the checksum instance; flags tx_dv during busy
   // and any change of tx_byte while the byte is on the wire.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         txBusyA  <= 1'b0;
         busyCntA <= 0;
      end else if (txBusyA) begin
         if ((txByteA !== holdA) || (txDvA !== 1'b0)) violA <= violA + 1;
         if (busyCntA == 1) begin
            txBusyA  <= 1'b0;
            fallCycA <= cyc;
         end else begin
            busyCntA <= busyCntA - 1;
         end
      end else if (txDvA === 1'b1) begin
         txBusyA  <= 1'b1;
         busyCntA <= BUSY_CYCLES;
         holdA    <= txByteA;
         logA.push_back(txByteA);
         dvCycA.push_back(cyc);
         dvCntA   <= dvCntA + 1;
      end
   end

   // uart_tx stand-in for the instance without checksum.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         txBusyB  <= 1'b0;
         busyCntB <= 0;
      end else if (txBusyB) begin
         if ((txByteB !== holdB) || (txDvB !== 1'b0)) violB <= violB + 1;
         if (busyCntB == 1) txBusyB <= 1'b0;
         else busyCntB <= busyCntB - 1;
      end else if (txDvB === 1'b1) begin
         txBusyB  <= 1'b1;
         busyCntB <= BUSY_CYCLES;
         holdB    <= txByteB;
         logB.push_back(txByteB);
         dvCntB   <= dvCntB + 1;
      end
   end

   // frame_done pulse counters with the sampling cycle of each pulse.
   always @(posedge clk) begin
      if (frameDoneA === 1'b1) begin
         doneCntA <= doneCntA + 1;
         doneCycA.push_back(cyc);
      end
      if (frameDoneB === 1'b1) doneCntB <= doneCntB + 1;
   end

   // in_ready must equal "not full" at all times outside reset.
   always @(negedge clk) begin
      if (!reset) begin
         if (inReadyA !== (fifoCountA != 5'd16)) readyViol <= readyViol + 1;
         if (int'(fifoCountA) > maxCountA) maxCountA <= int'(fifoCountA);
         if (inReadyA === 1'b0) sawFullA <= 1'b1;
      end
   end

   task automatic pushByte(input bit sel, input logic [7:0] b, input logic l);
      int n;
      @(negedge clk);
      if (!sel) begin
         inValidA = 1'b1; inByteA = b; inLastA = l;
      end else begin
         inValidB = 1'b1; inByteB = b; inLastB = l;
      end
      n = 0;
      while (((sel ? inReadyB : inReadyA) !== 1'b1) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         vectors++; miscompares++;
         $display("[TB] FAIL push_timeout in_ready stuck low, required 1");
      end
      lastPushCyc = cyc;
   endtask

   task automatic endPush();
      @(negedge clk);
      inValidA = 1'b0; inLastA = 1'b0;
      inValidB = 1'b0; inLastB = 1'b0;
   endtask

   task automatic waitDone(input bit sel, input int target, input int budget);
      int n;
      n = 0;
      while (((sel ? doneCntB : doneCntA) < target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         vectors++; miscompares++;
         $display("[TB] FAIL done_timeout frame_done count %0d, required %0d",
                  sel ? doneCntB : doneCntA, target);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inValidA = 1'b0; inByteA = 8'h00; inLastA = 1'b0;
      inValidB = 1'b0; inByteB = 8'h00; inLastB = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (txDvA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_dv got %b required 0", txDvA); end
      vectors++; if (txByteA !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_byte got %02h required 00", txByteA); end
      vectors++; if (frameDoneA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done got %b required 0", frameDoneA); end
      vectors++; if (fifoCountA !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_fifo_count got %0d required 0", fifoCountA); end
      vectors++; if (inReadyA !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b required 1", inReadyA); end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      vectors++; if (txDvA !== 1'b0 || txDvB !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_tx_dv got %b/%b required 0/0", txDvA, txDvB); end
   endtask

   task automatic test_basic_frame();
      logic [7:0] exp [5];
      int start, dv0, done0, pushAt;
      exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hFA};
      start = logA.size(); dv0 = dvCntA; done0 = doneCntA;
      pushByte(1'b0, 8'h01, 1'b0);
      pushAt = lastPushCyc;
      pushByte(1'b0, 8'h02, 1'b0);
      pushByte(1'b0, 8'h03, 1'b1);
      endPush();
      waitDone(1'b0, done0 + 1, 3000);
      // tx_dv is visible after the second edge past the push edge, so the
      // model samples it on the third edge.
      vectors++;
      if (dvCycA.size() <= start || dvCycA[start] - pushAt > 3) begin
         miscompares++;
         $display("[TB] FAIL first_sync_latency got %0d edges required <= 3",
                  dvCycA.size() > start ? dvCycA[start] - pushAt : -1);
      end
      vectors++; if (logA.size() - start != 5) begin miscompares++; $display("[TB] FAIL basic_len got %0d required 5", logA.size() - start); end
      for (int i = 0; i < 5; i++) begin
         logic [7:0] got;
         got = (start + i < logA.size()) ? logA[start + i] : 8'hxx;
         vectors++;
         if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL basic_byte%0d got %02h required %02h", i, got, exp[i]); end
      end
      vectors++; if (dvCntA - dv0 != 5) begin miscompares++; $display("[TB] FAIL basic_tx_dv_count got %0d required 5", dvCntA - dv0); end
      vectors++; if (doneCntA - done0 != 1) begin miscompares++; $display("[TB] FAIL basic_done_count got %0d required 1", doneCntA - done0); end
      vectors++;
      if (doneCycA.size() == 0 || doneCycA[doneCycA.size() - 1] <= fallCycA) begin
         miscompares++;
         $display("[TB] FAIL basic_done_after_busy got done edge %0d required after busy fall %0d",
                  doneCycA.size() > 0 ? doneCycA[doneCycA.size() - 1] : -1, fallCycA);
      end
   endtask

   task automatic test_no_checksum();
      int start, done0;
      start = logB.size(); done0 = doneCntB;
      pushByte(1'b1, 8'h7F, 1'b1);
      endPush();
      waitDone(1'b1, done0 + 1, 2000);
      vectors++; if (logB.size() - start != 2) begin miscompares++; $display("[TB] FAIL nocsum_len got %0d required 2", logB.size() - start); end
      vectors++; if (logB.size() > start && logB[start] !== 8'hA5) begin miscompares++; $display("[TB] FAIL nocsum_sync got %02h required A5", logB[start]); end
      vectors++; if (logB.size() > start + 1 && logB[start + 1] !== 8'h7F) begin miscompares++; $display("[TB] FAIL nocsum_byte got %02h required 7F", logB[start + 1]); end
      vectors++; if (doneCntB - done0 != 1) begin miscompares++; $display("[TB] FAIL nocsum_done_count got %0d required 1", doneCntB - done0); end
   endtask

   task automatic test_backpressure();
      int start, done0;
      start = logA.size(); done0 = doneCntA;
      // Payload 10..23 hex: sum is 1FE, so the checksum byte is 02.
      for (int i = 0; i < 20; i++) begin
         logic [7:0] b;
         b = 8'h10 + 8'(i);
         pushByte(1'b0, b, (i == 19));
      end
      endPush();
      waitDone(1'b0, done0 + 1, 5000);
      vectors++; if (sawFullA !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_in_ready_drop got never low required low when full"); end
      vectors++; if (maxCountA != 16) begin miscompares++; $display("[TB] FAIL bp_max_count got %0d required 16", maxCountA); end
      vectors++; if (logA.size() - start != 22) begin miscompares++; $display("[TB] FAIL bp_len got %0d required 22", logA.size() - start); end
      for (int i = 0; i < 22; i++) begin
         logic [7:0] got, want;
         got  = (start + i < logA.size()) ? logA[start + i] : 8'hxx;
         want = (i == 0) ? 8'hA5 : (i == 21) ? 8'h02 : 8'h0F + 8'(i);
         vectors++;
         if (got !== want) begin miscompares++; $display("[TB] FAIL bp_byte%0d got %02h required %02h", i, got, want); end
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp [4];
      int start, done0, dv0;
      exp = '{8'hA5, 8'h10, 8'h20, 8'hD0};
      start = logA.size(); done0 = doneCntA;
      pushByte(1'b0, 8'h10, 1'b0);
      endPush();
      repeat (200) @(negedge clk);
      dv0 = dvCntA;
      vectors++; if (logA.size() - start != 2) begin miscompares++; $display("[TB] FAIL stall_partial_len got %0d required 2", logA.size() - start); end
      vectors++; if (txBusyA !== 1'b0 || doneCntA != done0) begin miscompares++; $display("[TB] FAIL stall_idle got busy %b done %0d required 0 %0d", txBusyA, doneCntA, done0); end
      repeat (20) @(negedge clk);
      vectors++; if (dvCntA != dv0) begin miscompares++; $display("[TB] FAIL stall_no_dv got %0d required %0d", dvCntA, dv0); end
      pushByte(1'b0, 8'h20, 1'b1);
      endPush();
      waitDone(1'b0, done0 + 1, 2000);
      vectors++; if (logA.size() - start != 4) begin miscompares++; $display("[TB] FAIL stall_len got %0d required 4", logA.size() - start); end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] got;
         got = (start + i < logA.size()) ? logA[start + i] : 8'hxx;
         vectors++;
         if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL stall_byte%0d got %02h required %02h", i, got, exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [6];
      int start, done0, doneIdx;
      exp = '{8'hA5, 8'hAA, 8'h56, 8'hA5, 8'h55, 8'hAB};
      start = logA.size(); done0 = doneCntA; doneIdx = doneCycA.size();
      pushByte(1'b0, 8'hAA, 1'b1);
      pushByte(1'b0, 8'h55, 1'b1);
      endPush();
      waitDone(1'b0, done0 + 2, 4000);
      vectors++; if (doneCntA - done0 != 2) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d required 2", doneCntA - done0); end
      vectors++; if (logA.size() - start != 6) begin miscompares++; $display("[TB] FAIL b2b_len got %0d required 6", logA.size() - start); end
      for (int i = 0; i < 6; i++) begin
         logic [7:0] got;
         got = (start + i < logA.size()) ? logA[start + i] : 8'hxx;
         vectors++;
         if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL b2b_byte%0d got %02h required %02h", i, got, exp[i]); end
      end
      vectors++;
      if (doneCycA.size() <= doneIdx || dvCycA.size() <= start + 3 ||
          dvCycA[start + 3] - doneCycA[doneIdx] > 2 || dvCycA[start + 3] - doneCycA[doneIdx] < 1) begin
         miscompares++;
         $display("[TB] FAIL b2b_sync_gap got %0d cycles required 1..2",
                  (doneCycA.size() > doneIdx && dvCycA.size() > start + 3) ?
                  dvCycA[start + 3] - doneCycA[doneIdx] : -1);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] exp [3];
      int start, n, done0;
      exp = '{8'hA5, 8'h44, 8'hBC};
      start = logA.size();
      pushByte(1'b0, 8'h11, 1'b0);
      pushByte(1'b0, 8'h22, 1'b0);
      pushByte(1'b0, 8'h33, 1'b1);
      endPush();
      n = 0;
      while (!(logA.size() >= start + 2 && txBusyA === 1'b1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      vectors++; if (n >= 2000) begin miscompares++; $display("[TB] FAIL midreset_reach_payload got no busy payload byte required one"); end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++; if (txDvA !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_tx_dv got %b required 0", txDvA); end
      vectors++; if (txByteA !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_tx_byte got %02h required 00", txByteA); end
      vectors++; if (frameDoneA !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_frame_done got %b required 0", frameDoneA); end
      vectors++; if (fifoCountA !== 5'd0) begin miscompares++; $display("[TB] FAIL midreset_fifo_count got %0d required 0", fifoCountA); end
      vectors++; if (inReadyA !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_in_ready got %b required 1", inReadyA); end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      start = logA.size(); done0 = doneCntA;
      pushByte(1'b0, 8'h44, 1'b1);
      endPush();
      waitDone(1'b0, done0 + 1, 2000);
      vectors++; if (logA.size() - start != 3) begin miscompares++; $display("[TB] FAIL midreset_len got %0d required 3", logA.size() - start); end
      for (int i = 0; i < 3; i++) begin
         logic [7:0] got;
         got = (start + i < logA.size()) ? logA[start + i] : 8'hxx;
         vectors++;
         if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL midreset_byte%0d got %02h required %02h", i, got, exp[i]); end
      end
   endtask

   task automatic test_protocol();
      vectors++; if (violA != 0) begin miscompares++; $display("[TB] FAIL handshake_a got %0d violations required 0", violA); end
      vectors++; if (violB != 0) begin miscompares++; $display("[TB] FAIL handshake_b got %0d violations required 0", violB); end
      vectors++; if (readyViol != 0) begin miscompares++; $display("[TB] FAIL in_ready_vs_count got %0d violations required 0", readyViol); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_no_checksum();
      test_backpressure();
      test_stall();
      test_back_to_back();
      test_reset_mid_frame();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
